// File: rtl/cu_multicycle_if.sv
// Opcode handshake plus datapath control bundle between fetch and cu_multicycle.
interface cu_multicycle_if #(
  parameter int unsigned OPW  = 6,
  parameter int unsigned CNTW = 16
);
  logic            opcode_valid;
  logic [OPW-1:0]  opcode;
  logic            opcode_ready;
  logic            equ;
  logic            les;
  logic            trap_clr;
  logic [2:0]      im_control;
  logic [3:0]      alu_control;
  logic            dm_control;
  logic [6:0]      sel;
  logic            pc_en;
  logic            illegal;
  logic [CNTW-1:0] retired;

  modport master (
    output opcode_valid, opcode, equ, les, trap_clr,
    input  opcode_ready, im_control, alu_control, dm_control, sel, pc_en, illegal, retired
  );

  modport slave (
    input  opcode_valid, opcode, equ, les, trap_clr,
    output opcode_ready, im_control, alu_control, dm_control, sel, pc_en, illegal, retired
  );
endinterface

// File: rtl/cu_multicycle.sv
// Multi-cycle control unit: accepts one opcode, sequences EXEC / MEM wait / RETIRE,
// resolves branches from ALU flags, traps on illegal codes and counts retirements.
module cu_multicycle #(
  parameter int unsigned OPW      = 6,
  parameter int unsigned MEM_WAIT = 2,
  parameter int unsigned CNTW     = 16
) (
  input  logic            clk,
  input  logic            rst,
  cu_multicycle_if.slave  bus
);
  localparam int unsigned WAITW      = 4;
  localparam logic [6:0]  SEL_HOLD   = 7'h04;
  localparam bit          HAS_WAIT   = (MEM_WAIT != 0);
  localparam logic [WAITW-1:0] WAIT_LOAD = HAS_WAIT ? WAITW'(MEM_WAIT - 1) : '0;

  typedef enum logic [2:0] {IDLE, EXEC, MEM, RETIRE, TRAP} state_t;
  typedef enum logic [1:0] {BR_NONE, BR_EQU, BR_LES} br_t;

  state_t           state, state_nx;
  logic [WAITW-1:0] wait_q, wait_nx;
  logic [2:0]       im_q, im_nx;
  logic [3:0]       alu_q, alu_nx;
  logic             dm_q, dm_nx;
  logic [6:0]       sel_q, sel_nx;
  br_t              br_q, br_nx;
  logic             mem_q, mem_nx;
  logic             pc_en_q, pc_en_nx;
  logic             illegal_q, illegal_nx;
  logic [CNTW-1:0]  retired_q, retired_nx;

  logic [4:0] op;
  logic       legal;
  logic [2:0] d_im;
  logic [3:0] d_alu;
  logic       d_dm;
  logic [6:0] d_sel;
  br_t        d_br;
  logic       d_mem;
  logic [2:0] sel_lo;

  assign op    = bus.opcode[4:0];
  assign legal = (bus.opcode < OPW'(32));

  // Control decode of the opcode presented at the accept edge
  always_comb begin
    d_im  = 3'b000;
    d_alu = 4'd0;
    d_dm  = 1'b0;
    d_sel = 7'b1011011;
    d_br  = BR_NONE;
    d_mem = 1'b0;
    d_im[0] = (op < 5'd28);
    if (op >= 5'd1 && op <= 5'd15) begin
      d_im[2:1] = 2'd2;
      d_alu     = op[3:0];
    end else if (op >= 5'd24 && op <= 5'd27) begin
      d_im[2:1] = 2'd1;
      d_mem     = 1'b1;
    end
    d_dm = (op == 5'd25) || (op == 5'd27);
    case (op)
      5'd16, 5'd17, 5'd18: d_alu = 4'd1;
      5'd19:               d_alu = 4'd2;
      5'd20:               d_alu = 4'd3;
      5'd21:               d_alu = 4'd4;
      5'd22:               d_alu = 4'd9;
      5'd23:               d_alu = 4'd10;
      default: ;
    endcase
    case (op)
      5'd0:  d_sel[2:0] = 3'd4;
      5'd28: d_sel[2:0] = 3'd0;
      5'd29: d_sel[2:0] = 3'd2;
      5'd30: d_br       = BR_EQU;
      5'd31: d_br       = BR_LES;
      default: ;
    endcase
    d_sel[3] = !(op >= 5'd16 && op <= 5'd27);
    d_sel[4] = (op != 5'd27);
    case (op)
      5'd26:   d_sel[6:5] = 2'd0;
      5'd17:   d_sel[6:5] = 2'd1;
      5'd24:   d_sel[6:5] = 2'd3;
      default: d_sel[6:5] = 2'd2;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      wait_q    <= '0;
      im_q      <= '0;
      alu_q     <= '0;
      dm_q      <= 1'b0;
      sel_q     <= SEL_HOLD;
      br_q      <= BR_NONE;
      mem_q     <= 1'b0;
      pc_en_q   <= 1'b0;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state     <= state_nx;
      wait_q    <= wait_nx;
      im_q      <= im_nx;
      alu_q     <= alu_nx;
      dm_q      <= dm_nx;
      sel_q     <= sel_nx;
      br_q      <= br_nx;
      mem_q     <= mem_nx;
      pc_en_q   <= pc_en_nx;
      illegal_q <= illegal_nx;
      retired_q <= retired_nx;
    end
  end

  // Next state and next registered outputs; anything not set returns to idle values
  always_comb begin
    state_nx   = state;
    wait_nx    = wait_q;
    im_nx      = '0;
    alu_nx     = '0;
    dm_nx      = 1'b0;
    sel_nx     = SEL_HOLD;
    br_nx      = BR_NONE;
    mem_nx     = 1'b0;
    pc_en_nx   = 1'b0;
    illegal_nx = 1'b0;
    retired_nx = retired_q;
    case (state)
      IDLE: begin
        if (bus.opcode_valid) begin
          if (!legal) begin
            state_nx   = TRAP;
            illegal_nx = 1'b1;
          end else begin
            state_nx = EXEC;
            im_nx    = d_im;
            alu_nx   = d_alu;
            dm_nx    = d_dm;
            sel_nx   = d_sel;
            br_nx    = d_br;
            mem_nx   = d_mem;
          end
        end
      end
      EXEC: begin
        if (mem_q && HAS_WAIT) begin
          state_nx = MEM;
          wait_nx  = WAIT_LOAD;
          im_nx    = im_q;
          alu_nx   = alu_q;
          sel_nx   = sel_q;
          mem_nx   = mem_q;
        end else begin
          state_nx   = RETIRE;
          pc_en_nx   = 1'b1;
          retired_nx = retired_q + CNTW'(1);
        end
      end
      MEM: begin
        if (wait_q == '0) begin
          state_nx   = RETIRE;
          pc_en_nx   = 1'b1;
          retired_nx = retired_q + CNTW'(1);
        end else begin
          wait_nx = wait_q - WAITW'(1);
          im_nx   = im_q;
          alu_nx  = alu_q;
          sel_nx  = sel_q;
          mem_nx  = mem_q;
        end
      end
      RETIRE: state_nx = IDLE;
      TRAP: begin
        if (bus.trap_clr) state_nx = IDLE;
        else              illegal_nx = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Branch target select follows the live ALU flags during EXEC
  always_comb begin
    sel_lo = sel_q[2:0];
    if (state == EXEC) begin
      if (br_q == BR_EQU)      sel_lo = bus.equ ? 3'd1 : 3'd3;
      else if (br_q == BR_LES) sel_lo = bus.les ? 3'd1 : 3'd3;
    end
  end

  assign bus.opcode_ready = (state == IDLE) && !rst;
  assign bus.im_control   = im_q;
  assign bus.alu_control  = alu_q;
  assign bus.dm_control   = dm_q;
  assign bus.sel          = {sel_q[6:3], sel_lo};
  assign bus.pc_en        = pc_en_q;
  assign bus.illegal      = illegal_q;
  assign bus.retired      = retired_q;
endmodule

// File: tb/tb_cu_multicycle.sv
// Randomized bench for cu_multicycle against a table-driven instruction-level model.
module tb_cu_multicycle;
  localparam int unsigned OPW      = 6;
  localparam int unsigned MEM_WAIT = 2;
  localparam int unsigned CNTW     = 4;
  localparam logic [14:0] IDLE_CTRL = {3'd0, 4'd0, 1'b0, 7'h04};

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;
  int   n_ret = 0;
  int   alu_hi [8] = '{1, 1, 1, 2, 3, 4, 9, 10};

  always #5 clk = ~clk;

  cu_multicycle_if #(.OPW(OPW), .CNTW(CNTW)) bus ();

  cu_multicycle #(.OPW(OPW), .MEM_WAIT(MEM_WAIT), .CNTW(CNTW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected {im, alu, dm, sel} for an op, written straight from the opcode table
  function automatic logic [14:0] model(input int op, input bit e, input bit l, input bit first);
    int rd1, rd2, fn, we, pcs, in2, wd, wb;
    rd1 = (op >= 28) ? 0 : 1;
    rd2 = (op >= 1 && op <= 15) ? 2 : (op >= 24 && op <= 27) ? 1 : 0;
    fn  = (op >= 1 && op <= 15) ? op % 16 : (op >= 16 && op <= 23) ? alu_hi[op-16] : 0;
    we  = (first && (op == 25 || op == 27)) ? 1 : 0;
    pcs = 3;
    if (op == 0)  pcs = 4;
    if (op == 28) pcs = 0;
    if (op == 29) pcs = 2;
    if (op == 30) pcs = e ? 1 : 3;
    if (op == 31) pcs = l ? 1 : 3;
    in2 = (op >= 16 && op <= 27) ? 0 : 1;
    wd  = (op == 27) ? 0 : 1;
    wb  = (op == 26) ? 0 : (op == 17) ? 1 : (op == 24) ? 3 : 2;
    return {3'(rd2 * 2 + rd1), 4'(fn), 1'(we), 7'(wb * 32 + wd * 16 + in2 * 8 + pcs)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input int opc, input bit e, input bit l, input bit clr);
    bus.opcode_valid = v;
    bus.opcode       = OPW'(opc);
    bus.equ          = e;
    bus.les          = l;
    bus.trap_clr     = clr;
  endtask

  task automatic drive_junk();
    drive(1'($urandom % 2), int'($urandom_range(0, 63)), 1'($urandom % 2), 1'($urandom % 2),
          1'($urandom % 2));
  endtask

  task automatic check_ctrl(input string tag, input logic [14:0] exp);
    check({tag, ".im"},  32'(bus.im_control),  32'(exp[14:12]));
    check({tag, ".alu"}, 32'(bus.alu_control), 32'(exp[11:8]));
    check({tag, ".dm"},  32'(bus.dm_control),  32'(exp[7]));
    check({tag, ".sel"}, 32'(bus.sel),         32'(exp[6:0]));
  endtask

  task automatic check_status(input string tag, input bit rdy, input bit pce, input bit ill);
    check({tag, ".ready"},   32'(bus.opcode_ready), 32'(rdy));
    check({tag, ".pc_en"},   32'(bus.pc_en),        32'(pce));
    check({tag, ".illegal"}, 32'(bus.illegal),      32'(ill));
    check({tag, ".retired"}, 32'(bus.retired),      32'(n_ret % (1 << CNTW)));
  endtask

  // Issue one opcode from an IDLE cycle and follow it back to IDLE
  task automatic run_op(input int op, input bit e, input bit l);
    int k;
    bit mem;
    drive(1'b1, op, 1'($urandom % 2), 1'($urandom % 2), 1'($urandom % 2));
    if (op >= 32) begin
      k = int'($urandom_range(1, 3));
      for (int j = 1; j <= k; j++) begin
        tick();
        drive(1'($urandom % 2), int'($urandom_range(0, 63)), 1'($urandom % 2), 1'($urandom % 2),
              (j == k));
        #2;
        check_status("trap", 1'b0, 1'b0, 1'b1);
        check_ctrl("trap", IDLE_CTRL);
      end
    end else begin
      mem = (op >= 24 && op <= 27);
      tick();
      drive(1'($urandom % 2), int'($urandom_range(0, 63)), e, l, 1'($urandom % 2));
      #2;
      check_status("exec", 1'b0, 1'b0, 1'b0);
      check_ctrl("exec", model(op, e, l, 1'b1));
      if (mem) begin
        for (int j = 0; j < int'(MEM_WAIT); j++) begin
          tick();
          drive_junk();
          #2;
          check_status("mem", 1'b0, 1'b0, 1'b0);
          check_ctrl("mem", model(op, 1'b0, 1'b0, 1'b0));
        end
      end
      tick();
      drive_junk();
      #2;
      n_ret++;
      check_status("retire", 1'b0, 1'b1, 1'b0);
      check_ctrl("retire", IDLE_CTRL);
    end
    tick();
    drive(1'b0, 0, 1'($urandom % 2), 1'($urandom % 2), 1'($urandom % 2));
    #2;
    check_status("idle", 1'b1, 1'b0, 1'b0);
    check_ctrl("idle", IDLE_CTRL);
  endtask

  initial begin
    int op;
    drive(1'b0, 0, 1'b0, 1'b0, 1'b0);
    #1 rst = 1'b1;
    #1;
    check("rst.ready", 32'(bus.opcode_ready), 32'd0);
    check_ctrl("rst", IDLE_CTRL);
    check_status("rst", 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    #2;
    rst = 1'b0;
    tick();
    #2;
    check_status("post_rst", 1'b1, 1'b0, 1'b0);

    run_op(5, 1'b0, 1'b0);
    run_op(25, 1'b1, 1'b1);
    run_op(30, 1'b1, 1'b0);
    run_op(30, 1'b0, 1'b1);
    run_op(31, 1'b0, 1'b1);
    run_op(31, 1'b1, 1'b0);
    run_op(40, 1'b0, 1'b0);
    run_op(18, 1'b0, 1'b0);
    run_op(27, 1'b0, 1'b0);

    // Reset during the first memory-wait cycle of op 24 aborts it
    drive(1'b1, 24, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 0, 1'b0, 1'b0, 1'b0);
    #2;
    check_ctrl("rst24.exec", model(24, 1'b0, 1'b0, 1'b1));
    tick();
    #2;
    check_ctrl("rst24.mem", model(24, 1'b0, 1'b0, 1'b0));
    #1 rst = 1'b1;
    #1;
    n_ret = 0;
    check_status("rst24", 1'b0, 1'b0, 1'b0);
    check_ctrl("rst24", IDLE_CTRL);
    tick();
    #2;
    check_status("rst24.hold", 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    #2;
    check_status("rst24.idle", 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 17; i++) run_op(0, 1'($urandom % 2), 1'($urandom % 2));
    check("nop_wrap", 32'(bus.retired), 32'd1);

    for (int i = 0; i < 300; i++) begin
      if ($urandom % 8 == 0) op = int'($urandom_range(32, 63));
      else                   op = int'($urandom_range(0, 31));
      run_op(op, 1'($urandom % 2), 1'($urandom % 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
